// File: rtl/pb_pkg.sv
// Shared types and helpers for the pushbutton event controller.
package pb_pkg;

  // Per-channel hold/auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Default geometry, mirrored by the top-level parameter defaults.
  localparam int DEF_DEBOUNCE_CYC  = 500000;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Map a raw pin level to "1 = pressed".
  function automatic logic pb_norm(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

  // Counter widths for the default geometry.
  localparam int DEF_DB_W   = cnt_width(DEF_DEBOUNCE_CYC + 1);
  localparam int DEF_HOLD_W = cnt_width(max_int(DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD));

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: synchroniser, debouncer, hold/repeat FSM and
// the sticky flag/overrun registers seen by the consumer.
module pb_channel
  import pb_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  input  logic pb_read,
  output logic pb_flag,
  output logic pb_ovf,
  output logic pb_pressed
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  // Raw pin level that means "not pressed"; synchroniser resets to it so
  // leaving reset never looks like a press.
  localparam logic IDLE_RAW = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]        sync_reg;
  logic              sample;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic              pressed_reg, pressed_next;
  hold_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              evt;
  logic              flag_reg, flag_next;
  logic              ovf_reg, ovf_next;

  // Two-flop synchroniser on the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= {2{IDLE_RAW}};
    else     sync_reg <= {sync_reg[0], pb_raw};
  end

  assign sample = pb_norm(sync_reg[1], ACTIVE_LOW);

  // Debounce: count consecutive samples that disagree with the accepted
  // level; toggle when the count reaches DEBOUNCE_CYC, any agreement restarts.
  always_comb begin
    db_cnt_next  = '0;
    pressed_next = pressed_reg;
    if (sample != pressed_reg) begin
      if (db_cnt_reg == DB_LAST) pressed_next = ~pressed_reg;
      else                       db_cnt_next  = db_cnt_reg + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_reg  <= '0;
      pressed_reg <= 1'b0;
    end else begin
      db_cnt_reg  <= db_cnt_next;
      pressed_reg <= pressed_next;
    end
  end

  // Hold FSM: the first cycle seen pressed in IDLE is the press event;
  // a release always wins over a pending repeat.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    evt           = 1'b0;
    if (!pressed_reg) begin
      state_next    = IDLE;
      hold_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          evt           = 1'b1;
          state_next    = DELAY;
          hold_cnt_next = '0;
        end
        DELAY: begin
          if (hold_cnt_reg == DELAY_LAST) begin
            // Without auto-repeat the count parks here until release.
            if (REPEAT_EN) begin
              evt           = 1'b1;
              hold_cnt_next = '0;
              state_next    = REPEAT;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (hold_cnt_reg == PERIOD_LAST) begin
            evt           = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  // Hold FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Sticky flag/overrun next state: a new event always beats a read.
  always_comb begin
    flag_next = flag_reg;
    ovf_next  = ovf_reg;
    if (evt)          flag_next = 1'b1;
    else if (pb_read) flag_next = 1'b0;
    if (evt && flag_reg && !pb_read) ovf_next = 1'b1;
    else if (pb_read)                ovf_next = 1'b0;
  end

  // Flag and overrun registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      flag_reg <= flag_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign pb_flag    = flag_reg;
  assign pb_ovf     = ovf_reg;
  assign pb_pressed = pressed_reg;

endmodule

// File: rtl/pb_event_ctrl.sv
// N-channel pushbutton front end: one independent pb_channel per button.
module pb_event_ctrl
  import pb_pkg::*;
#(
  parameter int N_PB          = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_PB-1:0] pb_raw,
  input  logic [N_PB-1:0] pb_read,
  output logic [N_PB-1:0] pb_flag,
  output logic [N_PB-1:0] pb_ovf,
  output logic [N_PB-1:0] pb_pressed
);

  // Channels share nothing but the clock and reset.
  generate
    for (genvar gi = 0; gi < N_PB; gi++) begin : g_ch
      pb_channel #(
        .ACTIVE_LOW    (ACTIVE_LOW),
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .pb_raw     (pb_raw[gi]),
        .pb_read    (pb_read[gi]),
        .pb_flag    (pb_flag[gi]),
        .pb_ovf     (pb_ovf[gi]),
        .pb_pressed (pb_pressed[gi])
      );
    end
  endgenerate

endmodule
